multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multi-cycle control unit for the RV32I core; generalises the single-cycle R-type decoder into a sequenced FSM covering R, I-ALU, LOAD, STORE, BRANCH (BEQ/BNE), JAL and LUI. It drives the datapath's ALU select, operand muxes, register/PC/IR write enables and the instruction/data memory request handshakes. It sits between the instruction register and the existing ALU/regfile datapath. ALUSel encoding is unchanged from the single-cycle core.

Parameters:
TIMEOUT, 16, max cycles a memory request may wait for ready before trapping; 0 disables the timeout
CNT_W, 32, width of the performance counters (used only with PERF_CNT_EN)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
inst  in  32  instruction word from the instruction memory read port
imem_ready  in  1  instruction memory: data valid this cycle
dmem_ready  in  1  data memory: access complete this cycle
branch_taken  in  1  ALU compare result (rs1==rs2), sampled in EXEC
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
IRWEn  out  1  latch inst into IR
ALUSel  out  4  ALU operation, existing encoding
ALUSrcA  out  1  0=rs1, 1=zero (LUI)
ALUSrcB  out  1  0=rs2, 1=immediate
ImmSel  out  3  0=I,1=S,2=B,3=J,4=U
RegWEn  out  1  register file write
WBSel  out  2  0=ALU, 1=mem, 2=PC+4
PCWEn  out  1  PC update
PCSel  out  1  0=PC+4, 1=branch/jump target
trap  out  1  sticky; 1 = halted
trap_cause  out  2  0=none, 1=illegal instruction, 2=memory timeout
cycle_cnt  out  CNT_W  cycles since reset (PERF_CNT_EN only)
instret_cnt  out  CNT_W  retired instructions (PERF_CNT_EN only)

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Every output is registered from state/IR. On rst: state=FETCH, IR=0, all enables/requests=0, ALUSel=4'b0010, selects=0, trap=0, trap_cause=0, counters=0. rst wins over every other event, including mid-transaction or in TRAP.
- FETCH: imem_req=1 and held until imem_ready. On imem_ready: IRWEn pulses for one cycle, go to DECODE.
- DECODE: decode IR opcode, funct3 and inst[30]. Unknown opcode, BRANCH funct3 other than 000/001, or R-type funct7 other than 0000000/0100000 -> TRAP with cause 1.
- ALUSel map: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 1000, SLT 0111, SLTU 1001.
- I-ALU: funct3 000 is always ADD; SRAI when funct3=101 and inst[30]=1. LOAD, STORE, JAL and LUI use ADD. BRANCH uses SUB.
- EXEC, per type:
  - R / I-ALU / LUI / JAL: go to WB.
  - LOAD / STORE: go to MEM.
  - BRANCH: PCWEn=1; PCSel = branch_taken XOR funct3[0]; go to FETCH.
- MEM: dmem_req=1, with dmem_we=1 for STORE, held until dmem_ready. On dmem_ready: LOAD -> WB; STORE -> PCWEn=1, PCSel=0, go to FETCH.
- WB: RegWEn=1 for one cycle, suppressed when rd=x0. PCWEn=1, PCSel=1 for JAL else 0. WBSel: 1 for LOAD, 2 for JAL, else 0. Go to FETCH.
- Latency with zero wait states: R/I/LUI/JAL 4 cycles; LOAD 5; STORE 4; BRANCH 3.
- Timeout: a wait counter runs while imem_req or dmem_req is outstanding without ready. When it reaches TIMEOUT -> TRAP with cause 2; the request drops the same cycle. If ready arrives on the cycle the counter hits TIMEOUT, ready wins. The counter clears on every state change.
- TRAP: all enables and requests are 0; stays in TRAP until rst.
- A retire is the PCWEn pulse: exactly one per completed instruction.

Optional Feature:
PERF_CNT_EN:
- Defined: cycle_cnt increments every cycle outside reset, including in TRAP. instret_cnt increments on each PCWEn. Both wrap modulo 2^CNT_W.
- Undefined: counters and their ports are absent; all other behaviour is unchanged.

Test Plan:
- add x3,x1,x2 (0x002081B3), zero wait -> IRWEn at cycle 1; ALUSel=0010, RegWEn=1 at cycle 4 (WB); PCWEn=1 with PCSel=0 at cycle 4.
- srai (0x4030D193), sub (0x402081B3), sltu (0x0020B1B3) -> ALUSel 1000, 0110, 1001 respectively; ALUSrcB=1 for srai only.
- lw with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB with WBSel=1, RegWEn=1; total 8 cycles. sw -> dmem_we=1, RegWEn never asserted.
- bne with branch_taken=1 -> PCSel=0. beq with branch_taken=1 -> PCSel=1. Both assert PCWEn in cycle 3 with no RegWEn.
- opcode 0x7F -> trap=1, trap_cause=1, all enables 0; rst high for 1 cycle -> FETCH, trap=0.
- imem_ready held low, TIMEOUT=16 -> trap_cause=2 after 16 request cycles. Repeat with ready on cycle 16 -> no trap. With PERF_CNT_EN, 10 adds -> instret_cnt=10, cycle_cnt=40.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB and
//   drives the ALU/regfile datapath selects, write enables and memory handshakes.
//   Every output is a flop. Requests (imem_req, dmem_req, dmem_we) line up with
//   the state that owns them. Completion pulses (IRWEn, RegWEn, PCWEn with
//   PCSel/WBSel) appear in the cycle after the state that decides them.
//
//   Optional build macro: PERF_CNT_EN adds the cycle_cnt / instret_cnt ports.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   inst               instruction word from the instruction memory
//   imem_ready         instruction memory data valid
//   dmem_ready         data memory access complete
//   branch_taken       rs1==rs2 from the ALU, used in EXEC
//   imem_req           fetch request
//   dmem_req, dmem_we  data request / write (store)
//   IRWEn              instruction register load
//   ALUSel             ALU operation
//   ALUSrcA, ALUSrcB   operand muxes (A: 0=rs1 1=zero, B: 0=rs2 1=imm)
//   ImmSel             0=I 1=S 2=B 3=J 4=U
//   RegWEn, WBSel      register write, write-back source (0=ALU 1=mem 2=PC+4)
//   PCWEn, PCSel       PC update, 0=PC+4 1=target
//   trap, trap_cause   sticky halt, 1=illegal instruction 2=memory timeout
//   cycle_cnt          cycles since reset (PERF_CNT_EN)
//   instret_cnt        retired instructions (PERF_CNT_EN)
//
// state  | meaning
// FETCH  | request instruction, wait for imem_ready
// DECODE | classify IR, load ALU/operand selects or trap
// EXEC   | branch resolves here, others pick MEM or WB
// MEM    | data access, wait for dmem_ready
// WB     | register write and PC update
// TRAP   | halted until reset
module multicycle_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        IRWEn,
    output logic [3:0]  ALUSel,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic [2:0]  ImmSel,
    output logic        RegWEn,
    output logic [1:0]  WBSel,
    output logic        PCWEn,
    output logic        PCSel,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef PERF_CNT_EN
   ,output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] T_R     = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_LOAD  = 3'd2;
    localparam logic [2:0] T_STORE = 3'd3;
    localparam logic [2:0] T_BR    = 3'd4;
    localparam logic [2:0] T_JAL   = 3'd5;
    localparam logic [2:0] T_LUI   = 3'd6;
    localparam logic [2:0] T_BAD   = 3'd7;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Wait timer is a down-counter reloaded on every state change; it traps
    // on the request cycle where it already sits at zero.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    logic [2:0]    state;
    logic [2:0]    itype;
    logic [31:0]   ir;
    logic [TW-1:0] wait_cnt;
    logic          timeout_hit;

    logic [2:0] dec_type;
    logic [3:0] dec_alu;
    logic       dec_srca;
    logic       dec_srcb;
    logic [2:0] dec_imm;

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[24:15];

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == '0);

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = 4'b0100;
            3'b010:  op = 4'b0111;
            3'b011:  op = 4'b1001;
            3'b100:  op = 4'b0011;
            3'b101:  op = alt ? 4'b1000 : 4'b0101;
            3'b110:  op = 4'b0001;
            default: op = 4'b0000;
        endcase
        return op;
    endfunction

    always_comb begin
        dec_type = T_BAD;
        dec_alu  = ALU_ADD;
        dec_srca = 1'b0;
        dec_srcb = 1'b0;
        dec_imm  = 3'd0;
        case (ir[6:0])
            7'b0110011: begin
                dec_type = (ir[31:25] == 7'b0000000 || ir[31:25] == 7'b0100000) ? T_R : T_BAD;
                dec_alu  = alu_op(ir[14:12], ir[30]);
            end
            7'b0010011: begin
                // only SRAI uses inst[30]; ADDI never becomes SUB
                dec_type = T_I;
                dec_alu  = alu_op(ir[14:12], (ir[14:12] == 3'b101) && ir[30]);
                dec_srcb = 1'b1;
            end
            7'b0000011: begin
                dec_type = T_LOAD;
                dec_srcb = 1'b1;
            end
            7'b0100011: begin
                dec_type = T_STORE;
                dec_srcb = 1'b1;
                dec_imm  = 3'd1;
            end
            7'b1100011: begin
                dec_type = (ir[14:13] == 2'b00) ? T_BR : T_BAD;
                dec_alu  = ALU_SUB;
                dec_imm  = 3'd2;
            end
            7'b1101111: begin
                dec_type = T_JAL;
                dec_srcb = 1'b1;
                dec_imm  = 3'd3;
            end
            7'b0110111: begin
                dec_type = T_LUI;
                dec_srca = 1'b1;
                dec_srcb = 1'b1;
                dec_imm  = 3'd4;
            end
            default: dec_type = T_BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            itype      <= T_R;
            ir         <= '0;
            wait_cnt   <= WAIT_LOAD;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            IRWEn      <= 1'b0;
            ALUSel     <= ALU_ADD;
            ALUSrcA    <= 1'b0;
            ALUSrcB    <= 1'b0;
            ImmSel     <= 3'd0;
            RegWEn     <= 1'b0;
            WBSel      <= 2'd0;
            PCWEn      <= 1'b0;
            PCSel      <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
        end else begin
            IRWEn  <= 1'b0;
            RegWEn <= 1'b0;
            PCWEn  <= 1'b0;
            PCSel  <= 1'b0;
            WBSel  <= 2'd0;
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ready) begin
                        ir       <= inst;
                        IRWEn    <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                        wait_cnt <= WAIT_LOAD;
                    end else if (imem_req && timeout_hit) begin
                        imem_req   <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= 2'd2;
                        state      <= S_TRAP;
                        wait_cnt   <= WAIT_LOAD;
                    end else begin
                        // first FETCH after reset raises the request here
                        imem_req <= 1'b1;
                        if (imem_req && TIMEOUT != 0)
                            wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_DECODE: begin
                    wait_cnt <= WAIT_LOAD;
                    if (dec_type == T_BAD) begin
                        trap       <= 1'b1;
                        trap_cause <= 2'd1;
                        state      <= S_TRAP;
                    end else begin
                        itype   <= dec_type;
                        ALUSel  <= dec_alu;
                        ALUSrcA <= dec_srca;
                        ALUSrcB <= dec_srcb;
                        ImmSel  <= dec_imm;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= WAIT_LOAD;
                    if (itype == T_BR) begin
                        PCWEn    <= 1'b1;
                        PCSel    <= branch_taken ^ ir[12];
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else if (itype == T_LOAD || itype == T_STORE) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (itype == T_STORE);
                        state    <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        wait_cnt <= WAIT_LOAD;
                        if (itype == T_STORE) begin
                            PCWEn    <= 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (timeout_hit) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= 2'd2;
                        state      <= S_TRAP;
                        wait_cnt   <= WAIT_LOAD;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_WB: begin
                    RegWEn   <= (ir[11:7] != 5'd0);
                    PCWEn    <= 1'b1;
                    PCSel    <= (itype == T_JAL);
                    WBSel    <= (itype == T_LOAD) ? 2'd1 : (itype == T_JAL) ? 2'd2 : 2'd0;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                    wait_cnt <= WAIT_LOAD;
                end
                default: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    state    <= S_TRAP;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (PCWEn)
                instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction vectors, a small
// memory model with programmable wait states, and a retire-driven scoreboard.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        imem_ready, dmem_ready, branch_taken;
    logic        imem_req, dmem_req, dmem_we, IRWEn;
    logic [3:0]  ALUSel;
    logic        ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSel;
    logic        RegWEn;
    logic [1:0]  WBSel;
    logic        PCWEn, PCSel, trap;
    logic [1:0]  trap_cause;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_controller #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .inst(inst), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .IRWEn(IRWEn), .ALUSel(ALUSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSel(ImmSel), .RegWEn(RegWEn), .WBSel(WBSel), .PCWEn(PCWEn),
        .PCSel(PCSel), .trap(trap), .trap_cause(trap_cause)
`ifdef PERF_CNT_EN
       ,.cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] alu;
        logic       srca;
        logic       srcb;
        logic [2:0] imm;
        logic       rw;
        logic [1:0] wb;
        logic       pcsel;
        int         lat;
        int         dcyc;
        logic       we;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // memory model: ready once the request has waited *_delay cycles
    logic [31:0] cur_inst;
    int imem_delay, dmem_delay;
    int ireq_n = 0, dreq_n = 0;
    int cyc = 0, hs_cyc = 0;

    assign inst       = cur_inst;
    assign imem_ready = imem_req && (ireq_n >= imem_delay);
    assign dmem_ready = dmem_req && (dreq_n >= dmem_delay);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_req && imem_ready) hs_cyc <= cyc;
        if (rst) begin
            ireq_n <= 0;
            dreq_n <= 0;
        end else begin
            ireq_n <= (imem_req && !imem_ready) ? ireq_n + 1 : 0;
            dreq_n <= (dmem_req && !dmem_ready) ? dreq_n + 1 : 0;
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] alu, input logic srca, input logic srcb,
                                input logic [2:0] imm, input logic rw, input logic [1:0] wb,
                                input logic pcsel, input int lat, input int dcyc, input logic we);
        exp_t e;
        e.alu = alu; e.srca = srca; e.srcb = srcb; e.imm = imm; e.rw = rw;
        e.wb = wb; e.pcsel = pcsel; e.lat = lat; e.dcyc = dcyc; e.we = we;
        return e;
    endfunction

    // monitor: accumulate per-instruction activity, compare on each retire
    int   d_cnt = 0;
    logic we_seen = 1'b0, rw_seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            d_cnt = 0; we_seen = 1'b0; rw_seen = 1'b0;
        end else begin
            if (dmem_req) begin
                d_cnt++;
                if (dmem_we) we_seen = 1'b1;
            end
            if (RegWEn) rw_seen = 1'b1;
            if (IRWEn) chk("irwen_cycle", cyc - hs_cyc, 1);
            if (PCWEn) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_retire: got PCWEn, expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("alusel",   ALUSel,       e.alu);
                    chk("alusrca",  ALUSrcA,      e.srca);
                    chk("alusrcb",  ALUSrcB,      e.srcb);
                    chk("immsel",   ImmSel,       e.imm);
                    chk("regwen",   rw_seen,      e.rw);
                    chk("wbsel",    WBSel,        e.wb);
                    chk("pcsel",    PCSel,        e.pcsel);
                    chk("latency",  cyc - hs_cyc, e.lat);
                    chk("dmem_cyc", d_cnt,        e.dcyc);
                    chk("dmem_we",  we_seen,      e.we);
                end
                d_cnt = 0; we_seen = 1'b0; rw_seen = 1'b0;
            end
        end
    end

    task automatic run(input logic [31:0] ins, input int idly, input int ddly,
                       input logic bt, input exp_t e);
        int n;
        cur_inst = ins; imem_delay = idly; dmem_delay = ddly; branch_taken = bt;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!PCWEn && n < 100);
        if (!PCWEn) begin
            n_cmp++; n_bad++;
            $display("FAIL retire_wait: no PCWEn for %h, expected one within 100 cycles", ins);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_trap", trap, 0);
        chk("reset_cause", trap_cause, 0);
    endtask

    task automatic wait_trap(input string nm);
        int n;
        n = 0;
        while (!trap && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, trap, 1);
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SRAI = 32'h4030D193;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BNE  = 32'h00209063;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_ADD0 = 32'h00208033;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; cur_inst = '0; imem_delay = 0; dmem_delay = 0; branch_taken = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem", {dmem_req, dmem_we}, 0);
        chk("rst_enables", {IRWEn, RegWEn, PCWEn}, 0);
        chk("rst_alusel", ALUSel, 4'b0010);
        chk("rst_selects", {ALUSrcA, ALUSrcB, ImmSel, WBSel, PCSel}, 0);
        chk("rst_trap", {trap, trap_cause}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        //   inst    idly ddly bt      alu   A  B  imm rw wb pcs lat dc we
        run(I_ADD,  0, 0, 0, mk(4'b0010, 0, 0, 0, 1, 0, 0, 4, 0, 0));
        run(I_SRAI, 0, 0, 0, mk(4'b1000, 0, 1, 0, 1, 0, 0, 4, 0, 0));
        run(I_SUB,  0, 0, 0, mk(4'b0110, 0, 0, 0, 1, 0, 0, 4, 0, 0));
        run(I_SLTU, 0, 0, 0, mk(4'b1001, 0, 0, 0, 1, 0, 0, 4, 0, 0));
        run(I_LW,   0, 3, 0, mk(4'b0010, 0, 1, 0, 1, 1, 0, 8, 4, 0));
        run(I_LW,   0, 0, 0, mk(4'b0010, 0, 1, 0, 1, 1, 0, 5, 1, 0));
        run(I_SW,   0, 0, 0, mk(4'b0010, 0, 1, 1, 0, 0, 0, 4, 1, 1));
        run(I_SW,   0, 2, 0, mk(4'b0010, 0, 1, 1, 0, 0, 0, 6, 3, 1));
        run(I_BNE,  0, 0, 1, mk(4'b0110, 0, 0, 2, 0, 0, 0, 3, 0, 0));
        run(I_BEQ,  0, 0, 1, mk(4'b0110, 0, 0, 2, 0, 0, 1, 3, 0, 0));
        run(I_BNE,  0, 0, 0, mk(4'b0110, 0, 0, 2, 0, 0, 1, 3, 0, 0));
        run(I_BEQ,  0, 0, 0, mk(4'b0110, 0, 0, 2, 0, 0, 0, 3, 0, 0));
        run(I_JAL,  0, 0, 0, mk(4'b0010, 0, 1, 3, 1, 2, 1, 4, 0, 0));
        run(I_LUI,  0, 0, 0, mk(4'b0010, 1, 1, 4, 1, 0, 0, 4, 0, 0));
        run(I_ADD0, 0, 0, 0, mk(4'b0010, 0, 0, 0, 0, 0, 0, 4, 0, 0));
        run(I_ADD,  2, 0, 0, mk(4'b0010, 0, 0, 0, 1, 0, 0, 4, 0, 0));

        // illegal opcode follows directly
        cur_inst = 32'h0000007F;
        wait_trap("illegal_trap");
        chk("illegal_cause", trap_cause, 1);
        chk("trap_enables", {imem_req, dmem_req, dmem_we, IRWEn, RegWEn, PCWEn}, 0);
        repeat (5) @(negedge clk);
        chk("trap_sticky", {trap, trap_cause}, 3'b101);
        chk("trap_idle", {imem_req, PCWEn}, 0);
        do_reset();

        cur_inst = 32'h202081B3;
        wait_trap("bad_funct7_trap");
        chk("bad_funct7_cause", trap_cause, 1);
        do_reset();

        cur_inst = 32'h0020A063;
        wait_trap("bad_branch_trap");
        chk("bad_branch_cause", trap_cause, 1);

        // fetch never answered: trap on the 16th request cycle
        imem_delay = 100000;
        do_reset();
        n = 0;
        for (int i = 0; i < 100 && !trap; i++) begin
            @(negedge clk);
            if (imem_req) n++;
        end
        chk("imem_timeout_trap", {trap, trap_cause}, 3'b110);
        chk("imem_timeout_cycles", n, 16);

        // ready on the 16th request cycle wins over the timeout
        do_reset();
        run(I_ADD, 15, 0, 0, mk(4'b0010, 0, 0, 0, 1, 0, 0, 4, 0, 0));
        chk("late_ready_no_trap", trap, 0);

        // data side never answers
        cur_inst = I_LW; imem_delay = 0; dmem_delay = 100000;
        n = 0;
        for (int i = 0; i < 100 && !trap; i++) begin
            @(negedge clk);
            if (dmem_req) n++;
        end
        chk("dmem_timeout_trap", {trap, trap_cause}, 3'b110);
        chk("dmem_timeout_cycles", n, 16);
        dmem_delay = 0;

`ifdef PERF_CNT_EN
        begin
            int c0;
            cur_inst = I_ADD; imem_delay = 0;
            do_reset();
            for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
            c0 = cycle_cnt;
            for (int i = 0; i < 10; i++)
                run(I_ADD, 0, 0, 0, mk(4'b0010, 0, 0, 0, 1, 0, 0, 4, 0, 0));
            imem_delay = 100000;
            chk("perf_cycles", cycle_cnt - c0, 40);
            @(negedge clk);
            chk("perf_instret", instret_cnt, 10);
        end
`endif

        imem_delay = 100000;
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
